// File: rtl/bounce_gen_multi_if.sv
// Handshake-free signal bundle between the stimulus side and bounce_gen_multi.
// Ports: bypass (1), sig_in (NUM_CH) from master; bounce_out, busy, done (NUM_CH) from slave.
// The master drives the clean levels and bypass; the slave returns the bouncy levels and status.
interface bounce_gen_multi_if #(
  parameter int NUM_CH = 1
);
  logic              bypass;
  logic [NUM_CH-1:0] sig_in;
  logic [NUM_CH-1:0] bounce_out;
  logic [NUM_CH-1:0] busy;
  logic [NUM_CH-1:0] done;

  modport master (
    output bypass,
    output sig_in,
    input  bounce_out,
    input  busy,
    input  done
  );

  modport slave (
    input  bypass,
    input  sig_in,
    output bounce_out,
    output busy,
    output done
  );
endinterface

// File: rtl/bounce_gen_multi.sv
// Purpose: per-channel bounce generator; turns clean level changes into LFSR-randomised bouncy waveforms.
// Latency: a differing sig_in shows on bounce_out at the same sampling edge; bypass gives one clock.
// Backpressure: none; sig_in changes during a sequence are ignored until the channel is idle again.
// Ports: clk, rst_n (async active-low); bus (slave modport): bypass, sig_in in; bounce_out, busy, done out.
// The interface instance must be parameterised with the same NUM_CH as this module.
module bounce_gen_multi #(
  parameter int          NUM_CH                   = 1,
  parameter int          BOUNCE_CLOCKS_LOW_RANGE  = 10,
  parameter int          BOUNCE_CLOCKS_HIGH_RANGE = 1000,
  parameter int          NUM_BOUNCES_LOW_RANGE    = 2,
  parameter int          NUM_BOUNCES_HIGH_RANGE   = 5,
  parameter logic [15:0] LFSR_SEED                = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst_n,
  bounce_gen_multi_if.slave bus
);

  localparam int          CW     = $clog2(BOUNCE_CLOCKS_HIGH_RANGE + 1);
  localparam int          PW     = $clog2(NUM_BOUNCES_HIGH_RANGE + 1);
  localparam int unsigned D_SPAN = unsigned'(BOUNCE_CLOCKS_HIGH_RANGE - BOUNCE_CLOCKS_LOW_RANGE + 1);
  localparam int unsigned N_SPAN = unsigned'(NUM_BOUNCES_HIGH_RANGE - NUM_BOUNCES_LOW_RANGE + 1);
  localparam logic [15:0] TAPS   = 16'hB400;

  if (NUM_CH < 1) begin : g_bad_ch
    $fatal(1, "bounce_gen_multi: NUM_CH must be >= 1");
  end
  if (BOUNCE_CLOCKS_LOW_RANGE < 1) begin : g_bad_bl
    $fatal(1, "bounce_gen_multi: BOUNCE_CLOCKS_LOW_RANGE must be >= 1");
  end
  if (BOUNCE_CLOCKS_HIGH_RANGE < BOUNCE_CLOCKS_LOW_RANGE) begin : g_bad_bh
    $fatal(1, "bounce_gen_multi: BOUNCE_CLOCKS_HIGH_RANGE must be >= LOW");
  end
  if (NUM_BOUNCES_LOW_RANGE < 1) begin : g_bad_nl
    $fatal(1, "bounce_gen_multi: NUM_BOUNCES_LOW_RANGE must be >= 1");
  end
  if (NUM_BOUNCES_HIGH_RANGE < NUM_BOUNCES_LOW_RANGE) begin : g_bad_nh
    $fatal(1, "bounce_gen_multi: NUM_BOUNCES_HIGH_RANGE must be >= LOW");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ON,
    ST_OFF
  } state_t;

  // Phase length minus one: the counter runs d-1 .. 0 so the phase spans exactly d clocks.
  function automatic logic [CW-1:0] draw_phase_m1(input logic [15:0] v);
    return CW'(32'(BOUNCE_CLOCKS_LOW_RANGE - 1) + (32'(v) % D_SPAN));
  endfunction

  function automatic logic [PW-1:0] draw_pairs(input logic [15:0] v);
    return PW'(32'(NUM_BOUNCES_LOW_RANGE) + (32'(v) % N_SPAN));
  endfunction

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    localparam logic [15:0] SEED_X = LFSR_SEED ^ 16'(i + 1);
    localparam logic [15:0] SEED   = (SEED_X == 16'h0000) ? 16'h0001 : SEED_X;

    state_t          state_q, state_d;
    logic            out_q, out_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            tgt_q, tgt_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   pairs_q, pairs_d;
    logic [15:0]     lfsr_q, lfsr_d;

    always_comb begin
      state_d = state_q;
      out_d   = out_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      tgt_d   = tgt_q;
      cnt_d   = cnt_q;
      pairs_d = pairs_q;
      // Galois step; free-running regardless of mode so draws stay decorrelated.
      lfsr_d  = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? TAPS : 16'h0000);

      if (bus.bypass) begin
        // Abandon any sequence; output simply follows the input one clock late.
        state_d = ST_IDLE;
        out_d   = bus.sig_in[i];
        busy_d  = 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (bus.sig_in[i] != out_q) begin
              tgt_d   = bus.sig_in[i];
              pairs_d = draw_pairs(lfsr_q);
              cnt_d   = draw_phase_m1(lfsr_q);
              out_d   = bus.sig_in[i];
              busy_d  = 1'b1;
              state_d = ST_ON;
            end
          end
          ST_ON: begin
            if (cnt_q == '0) begin
              cnt_d   = draw_phase_m1(lfsr_q);
              out_d   = ~tgt_q;
              state_d = ST_OFF;
            end else begin
              cnt_d = cnt_q - CW'(1);
            end
          end
          ST_OFF: begin
            if (cnt_q == '0) begin
              pairs_d = pairs_q - PW'(1);
              out_d   = tgt_q;
              if (pairs_d != '0) begin
                cnt_d   = draw_phase_m1(lfsr_q);
                state_d = ST_ON;
              end else begin
                // Final settle to target coincides with busy falling and done pulsing.
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = ST_IDLE;
              end
            end else begin
              cnt_d = cnt_q - CW'(1);
            end
          end
          default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end
        endcase
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= ST_IDLE;
        out_q   <= 1'b0;
        busy_q  <= 1'b0;
        done_q  <= 1'b0;
        tgt_q   <= 1'b0;
        cnt_q   <= '0;
        pairs_q <= '0;
        lfsr_q  <= SEED;
      end else begin
        state_q <= state_d;
        out_q   <= out_d;
        busy_q  <= busy_d;
        done_q  <= done_d;
        tgt_q   <= tgt_d;
        cnt_q   <= cnt_d;
        pairs_q <= pairs_d;
        lfsr_q  <= lfsr_d;
      end
    end

    assign bus.bounce_out[i] = out_q;
    assign bus.busy[i]       = busy_q;
    assign bus.done[i]       = done_q;
  end

endmodule

// File: tb/tb_bounce_gen_multi.sv
module tb_bounce_gen_multi;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  bounce_gen_multi_if #(.NUM_CH(2)) if_fix ();
  bounce_gen_multi_if #(.NUM_CH(1)) if_rnd ();

  // Fixed ranges: every phase 4 clocks, 3 pairs per sequence.
  bounce_gen_multi #(
    .NUM_CH(2),
    .BOUNCE_CLOCKS_LOW_RANGE(4),
    .BOUNCE_CLOCKS_HIGH_RANGE(4),
    .NUM_BOUNCES_LOW_RANGE(3),
    .NUM_BOUNCES_HIGH_RANGE(3)
  ) u_fix (
    .clk(clk),
    .rst_n(rst_n),
    .bus(if_fix)
  );

  // Narrow random ranges so bounds are reachable in a short run.
  bounce_gen_multi #(
    .NUM_CH(1),
    .BOUNCE_CLOCKS_LOW_RANGE(3),
    .BOUNCE_CLOCKS_HIGH_RANGE(6),
    .NUM_BOUNCES_LOW_RANGE(2),
    .NUM_BOUNCES_HIGH_RANGE(3)
  ) u_rnd (
    .clk(clk),
    .rst_n(rst_n),
    .bus(if_rnd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input int v, input int lo, input int hi);
    checks++;
    assert (v >= lo && v <= hi) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=[%0d,%0d]", tag, v, lo, hi);
    end
  endtask

  // Drive one transition on the random instance and measure its phases.
  task automatic rnd_seq(input logic tgt);
    int   len;
    int   phases;
    logic prev;
    bit   got;
    if_rnd.sig_in = tgt;
    tick();
    chk("rnd_start_out", 32'(if_rnd.bounce_out), 32'(tgt));
    chk("rnd_start_busy", 32'(if_rnd.busy), 32'd1);
    prev   = tgt;
    len    = 0;
    phases = 0;
    got    = 0;
    for (int c = 0; c < 100 && !got; c++) begin
      tick();
      len++;
      if (if_rnd.bounce_out[0] !== prev) begin
        chk_rng("rnd_phase_len", len, 3, 6);
        phases++;
        len  = 0;
        prev = if_rnd.bounce_out[0];
      end
      if (if_rnd.done[0] === 1'b1) got = 1;
    end
    chk("rnd_done_seen", 32'(got), 32'd1);
    chk("rnd_final_out", 32'(if_rnd.bounce_out), 32'(tgt));
    chk("rnd_busy_end", 32'(if_rnd.busy), 32'd0);
    chk("rnd_phase_even", 32'(phases % 2), 32'd0);
    chk_rng("rnd_pairs", phases / 2, 2, 3);
    tick();
    chk("rnd_done_one_cycle", 32'(if_rnd.done), 32'd0);
  endtask

  logic [1:0] pats [4];
  logic [1:0] prev_p;
  logic       exp_b;

  initial begin
    checks = 0;
    errors = 0;
    pats   = '{2'b11, 2'b00, 2'b01, 2'b10};

    // Reset with inputs high.
    rst_n         = 1'b0;
    if_fix.bypass = 1'b0;
    if_fix.sig_in = 2'b11;
    if_rnd.bypass = 1'b0;
    if_rnd.sig_in = 1'b1;
    #22;
    chk("rst_out", 32'(if_fix.bounce_out), 32'd0);
    chk("rst_busy", 32'(if_fix.busy), 32'd0);
    chk("rst_done", 32'(if_fix.done), 32'd0);
    chk("rst_rnd_out", 32'(if_rnd.bounce_out), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_out", 32'(if_fix.bounce_out), 32'h3);
    chk("post_rst_busy", 32'(if_fix.busy), 32'h3);
    chk("post_rst_rnd_busy", 32'(if_rnd.busy), 32'd1);
    repeat (40) tick();
    chk("post_rst_settle_out", 32'(if_fix.bounce_out), 32'h3);
    chk("post_rst_settle_busy", 32'(if_fix.busy), 32'h0);
    chk("post_rst_rnd_settle", 32'(if_rnd.bounce_out), 32'd1);

    // Bring both fixed channels low, then exact ch0 0->1 waveform.
    if_fix.sig_in = 2'b00;
    repeat (30) tick();
    chk("low_settle", 32'(if_fix.bounce_out), 32'h0);
    if_fix.sig_in = 2'b01;
    tick();
    for (int j = 0; j <= 25; j++) begin
      exp_b = (j < 24) ? (((j / 4) % 2) == 0) : 1'b1;
      chk($sformatf("wave_out_%0d", j), 32'(if_fix.bounce_out), 32'({1'b0, exp_b}));
      chk($sformatf("wave_busy_%0d", j), 32'(if_fix.busy), 32'({1'b0, (j < 24)}));
      chk($sformatf("wave_done_%0d", j), 32'(if_fix.done), 32'({1'b0, (j == 24)}));
      tick();
    end

    // Revert mid-sequence: completes to 1, then restarts toward 0.
    if_fix.sig_in = 2'b00;
    repeat (30) tick();
    chk("rev_pre_low", 32'(if_fix.bounce_out), 32'h0);
    if_fix.sig_in = 2'b01;
    tick();
    repeat (2) tick();
    if_fix.sig_in = 2'b00;
    repeat (22) tick();
    chk("rev_end_out", 32'(if_fix.bounce_out), 32'h1);
    chk("rev_end_done", 32'(if_fix.done), 32'h1);
    chk("rev_end_busy", 32'(if_fix.busy), 32'h0);
    tick();
    chk("rev_restart_out", 32'(if_fix.bounce_out), 32'h0);
    chk("rev_restart_busy", 32'(if_fix.busy), 32'h1);
    chk("rev_restart_done", 32'(if_fix.done), 32'h0);
    repeat (24) tick();
    chk("rev_final_out", 32'(if_fix.bounce_out), 32'h0);
    chk("rev_final_done", 32'(if_fix.done), 32'h1);
    chk("rev_final_busy", 32'(if_fix.busy), 32'h0);
    tick();

    // Bypass asserted mid-sequence aborts on the next edge.
    if_fix.sig_in = 2'b01;
    tick();
    chk("byp_pre_busy", 32'(if_fix.busy), 32'h1);
    repeat (2) tick();
    if_fix.bypass = 1'b1;
    if_fix.sig_in = 2'b10;
    tick();
    chk("byp_abort_out", 32'(if_fix.bounce_out), 32'h2);
    chk("byp_abort_busy", 32'(if_fix.busy), 32'h0);
    chk("byp_abort_done", 32'(if_fix.done), 32'h0);
    prev_p = 2'b10;
    for (int p = 0; p < 4; p++) begin
      if_fix.sig_in = pats[p];
      chk($sformatf("byp_hold_%0d", p), 32'(if_fix.bounce_out), 32'(prev_p));
      tick();
      chk($sformatf("byp_out_%0d", p), 32'(if_fix.bounce_out), 32'(pats[p]));
      chk($sformatf("byp_busy_%0d", p), 32'(if_fix.busy), 32'h0);
      prev_p = pats[p];
    end
    if_fix.bypass = 1'b0;
    tick();
    chk("byp_exit_busy", 32'(if_fix.busy), 32'h0);
    chk("byp_exit_out", 32'(if_fix.bounce_out), 32'h2);
    repeat (5) tick();
    chk("byp_exit_quiet", 32'(if_fix.busy), 32'h0);

    // Random-range transitions.
    rnd_seq(1'b0);
    rnd_seq(1'b1);
    rnd_seq(1'b0);
    rnd_seq(1'b1);
    rnd_seq(1'b0);
    rnd_seq(1'b1);

    // Async reset mid-sequence on ch1.
    if_fix.sig_in = 2'b00;
    repeat (30) tick();
    chk("ar_pre_low", 32'(if_fix.bounce_out), 32'h0);
    if_fix.sig_in = 2'b10;
    tick();
    chk("ar_start_out", 32'(if_fix.bounce_out), 32'h2);
    chk("ar_start_busy", 32'(if_fix.busy), 32'h2);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_async_out", 32'(if_fix.bounce_out), 32'h0);
    chk("ar_async_busy", 32'(if_fix.busy), 32'h0);
    chk("ar_async_done", 32'(if_fix.done), 32'h0);
    repeat (3) begin
      tick();
      chk("ar_hold_done", 32'(if_fix.done), 32'h0);
      chk("ar_hold_busy", 32'(if_fix.busy), 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("ar_restart_out", 32'(if_fix.bounce_out), 32'h2);
    chk("ar_restart_busy", 32'(if_fix.busy), 32'h2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
